// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request, ALU-drive and response signals of the ALU
// issue controller. The slave modport is the sequencer; the master modport
// is its environment (decode stage, ALU and response consumer).
interface alu_sequencer_if;
  // Request channel from decode
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_fun_sel;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_cond;
  logic        req_setf;
  // ALU drive and return
  logic [4:0]  fun_sel;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_cin;
  logic [31:0] alu_out;
  logic [3:0]  alu_flags;
  // Response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_flags;
  logic        rsp_skipped;

  modport slave (
    input  req_valid, req_fun_sel, req_a, req_b, req_cond, req_setf,
    input  alu_out, alu_flags, rsp_ready,
    output req_ready, fun_sel, alu_a, alu_b, alu_cin,
    output rsp_valid, rsp_data, rsp_flags, rsp_skipped
  );

  modport master (
    output req_valid, req_fun_sel, req_a, req_b, req_cond, req_setf,
    output alu_out, alu_flags, rsp_ready,
    input  req_ready, fun_sel, alu_a, alu_b, alu_cin,
    input  rsp_valid, rsp_data, rsp_flags, rsp_skipped
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle issue controller for the 32-bit ALU.
// Accepts one operation at a time, evaluates its condition against shadow
// flags {Z,C,N,V}, holds the ALU inputs for the ALU's registered latency,
// then returns result and flags on a valid/ready response channel.
// Optional macro ALU_SEQ_STATS_EN adds stat_issued / stat_skipped counters.
module alu_sequencer #(
  parameter int RESULT_LATENCY = 1,  // 1..7
  parameter int FLAG_LATENCY   = 2   // 1..7
) (
  input  logic             clock,
  input  logic             reset,
  alu_sequencer_if.slave   bus
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]      stat_issued,
  output logic [15:0]      stat_skipped
`endif
);

  localparam int MAX_LAT_INT = (RESULT_LATENCY > FLAG_LATENCY) ? RESULT_LATENCY : FLAG_LATENCY;
  localparam logic [2:0] RES_LAT  = 3'(RESULT_LATENCY);
  localparam logic [2:0] FLAG_LAT = 3'(FLAG_LATENCY);
  localparam logic [2:0] MAX_LAT  = 3'(MAX_LAT_INT);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q;
  logic [4:0]  fun_sel_q;
  logic [31:0] alu_a_q, alu_b_q;
  logic [2:0]  cond_q;
  logic        setf_q;
  logic [3:0]  shadow_q;     // {Z,C,N,V} of the last committed operation
  logic [31:0] rsp_data_q;
  logic        rsp_skipped_q;
  logic        cond_true;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Condition code evaluated against the shadow flags {Z,C,N,V}.
  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cond_true = 1'b0;
    case (cond_q)
      3'b000: cond_true = 1'b1;
      3'b001: cond_true = shadow_q[3];
      3'b010: cond_true = !shadow_q[3];
      3'b011: cond_true = shadow_q[2];
      3'b100: cond_true = !shadow_q[2];
      3'b101: cond_true = shadow_q[1];
      3'b110: cond_true = !shadow_q[1];
      3'b111: cond_true = shadow_q[0];
      default: cond_true = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.req_valid) state_d = S_EVAL;
      S_EVAL: state_d = cond_true ? S_WAIT : S_RESP;
      S_WAIT: if (cnt_q == MAX_LAT) state_d = S_RESP;
      S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, latency counter, result capture and flag commit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      fun_sel_q     <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      cond_q        <= '0;
      setf_q        <= 1'b0;
      shadow_q      <= '0;
      rsp_data_q    <= '0;
      rsp_skipped_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            fun_sel_q <= bus.req_fun_sel;
            alu_a_q   <= bus.req_a;
            alu_b_q   <= bus.req_b;
            cond_q    <= bus.req_cond;
            setf_q    <= bus.req_setf;
          end
        end
        S_EVAL: begin
          if (cond_true) begin
            cnt_q         <= 3'd1;
            rsp_skipped_q <= 1'b0;
          end else begin
            rsp_skipped_q <= 1'b1;
            rsp_data_q    <= '0;
          end
        end
        S_WAIT: begin
          if (cnt_q == RES_LAT) rsp_data_q <= bus.alu_out;
          if (cnt_q == FLAG_LAT && setf_q) shadow_q <= bus.alu_flags;
          if (cnt_q != MAX_LAT) cnt_q <= cnt_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  // Issue/skip counters; wrap naturally at 16 bits.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_issued  <= '0;
      stat_skipped <= '0;
    end else if (state_q == S_EVAL) begin
      if (cond_true) stat_issued  <= stat_issued + 16'd1;
      else           stat_skipped <= stat_skipped + 16'd1;
    end
  end
`endif

  assign bus.req_ready   = (state_q == S_IDLE);
  assign bus.fun_sel     = fun_sel_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_cin     = shadow_q[2];
  assign bus.rsp_valid   = (state_q == S_RESP);
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_flags   = shadow_q;
  assign bus.rsp_skipped = rsp_skipped_q;

endmodule
